// File: rtl/cdb_broadcast_queue.sv
// Completion broadcast queue: gathers finished destination tags from the FU result
// lanes and drives up to N_WAY of them per cycle onto the CDB, oldest first.
module cdb_broadcast_queue #(
  parameter int N_WAY    = 2,
  parameter int N_FU     = 4,
  parameter int CDB_BITS = 6,
  parameter int DEPTH    = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N_FU-1:0]                fu_done_valid,
  input  logic [N_FU-1:0][CDB_BITS-1:0]  fu_done_tag,
  output logic                           fu_ready,
  output logic [N_WAY-1:0][CDB_BITS-1:0] complete_dest_tag,
  output logic [$clog2(DEPTH+1)-1:0]     queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] N_FU_C  = CNT_W'(N_FU);
  localparam logic [CNT_W-1:0] N_WAY_C = CNT_W'(N_WAY);

  logic [CDB_BITS-1:0]            mem_q [DEPTH];
  logic [CDB_BITS-1:0]            mem_d [DEPTH];
  logic [PTR_W-1:0]               head_q, head_d;
  logic [PTR_W-1:0]               tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [N_WAY-1:0][CDB_BITS-1:0] cdb_q, cdb_d;

  logic [N_FU-1:0]                lane_acc;
  logic [N_FU-1:0][CNT_W-1:0]     pos;
  logic [CNT_W-1:0]               n_acc;
  logic [CNT_W-1:0]               total;
  logic [CNT_W-1:0]               from_q;
  logic [CNT_W-1:0]               k;
  logic [CNT_W-1:0]               used_acc;
  logic [CNT_W-1:0]               n_wr;

  // Depends on the count register only, so FUs see a stable ready all cycle.
  assign fu_ready = (DEPTH_C - count_q) >= N_FU_C;

  // pos[i] is the rank of lane i among this cycle's accepted lanes.
  always_comb begin
    lane_acc = '0;
    pos      = '0;
    n_acc    = '0;
    for (int i = 0; i < N_FU; i++) begin
      pos[i]      = n_acc;
      lane_acc[i] = fu_ready && fu_done_valid[i] && (fu_done_tag[i] != '0);
      if (lane_acc[i]) n_acc = n_acc + CNT_W'(1);
    end
  end

  always_comb begin
    total    = count_q + n_acc;
    from_q   = (count_q < N_WAY_C) ? count_q : N_WAY_C;
    k        = (total < N_WAY_C) ? total : N_WAY_C;
    used_acc = k - from_q;
    n_wr     = n_acc - used_acc;
  end

  // Queue entries fill the low CDB lanes; accepted lanes follow in index order.
  always_comb begin
    cdb_d = '0;
    for (int j = 0; j < N_WAY; j++) begin
      if (CNT_W'(j) < from_q) begin
        cdb_d[j] = mem_q[head_q + PTR_W'(j)];
      end else begin
        for (int i = 0; i < N_FU; i++) begin
          if (lane_acc[i] && (pos[i] + from_q == CNT_W'(j))) cdb_d[j] = fu_done_tag[i];
        end
      end
    end
  end

  // Accepted lanes that did not fit on the bus land at the tail in rank order.
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < DEPTH; s++) begin
      for (int i = 0; i < N_FU; i++) begin
        if (lane_acc[i] && (pos[i] >= used_acc) &&
            (tail_q + PTR_W'(pos[i] - used_acc) == PTR_W'(s))) begin
          mem_d[s] = fu_done_tag[i];
        end
      end
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(from_q);
    tail_d  = tail_q + PTR_W'(n_wr);
    count_d = count_q + n_acc - k;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cdb_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      cdb_q   <= cdb_d;
    end
  end

  // Storage needs no reset: entries are only read between head and count.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign complete_dest_tag = cdb_q;
  assign queue_count       = count_q;

endmodule

// File: tb/tb_cdb_broadcast_queue.sv
// Directed bench for cdb_broadcast_queue at default parameters (N_WAY=2, N_FU=4, DEPTH=8).
module tb_cdb_broadcast_queue;

  logic            clock;
  logic            reset;
  logic [3:0]      fu_done_valid;
  logic [3:0][5:0] fu_done_tag;
  logic            fu_ready;
  logic [1:0][5:0] complete_dest_tag;
  logic [3:0]      queue_count;

  int n_checks = 0;
  int n_fail   = 0;

  cdb_broadcast_queue #(.N_WAY(2), .N_FU(4), .CDB_BITS(6), .DEPTH(8)) dut (
    .clock             (clock),
    .reset             (reset),
    .fu_done_valid     (fu_done_valid),
    .fu_done_tag       (fu_done_tag),
    .fu_ready          (fu_ready),
    .complete_dest_tag (complete_dest_tag),
    .queue_count       (queue_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fu_done_valid = '0;
    fu_done_tag   = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    n_checks++;
    if (complete_dest_tag !== 12'h000) begin
      n_fail++; $display("FAIL reset_cdb: got %h expected 000", complete_dest_tag);
    end
    n_checks++;
    if (queue_count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", queue_count);
    end
    n_checks++;
    if (fu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", fu_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    fu_done_valid  = 4'b0100;
    fu_done_tag[2] = 6'd5;
    cyc();
    clear_inputs();
    n_checks++;
    if (complete_dest_tag[0] !== 6'd5 || complete_dest_tag[1] !== 6'd0) begin
      n_fail++; $display("FAIL single_out: got %0d,%0d expected 5,0",
                         complete_dest_tag[0], complete_dest_tag[1]);
    end
    n_checks++;
    if (queue_count !== 4'd0) begin
      n_fail++; $display("FAIL single_count: got %0d expected 0", queue_count);
    end
    cyc();
    n_checks++;
    if (complete_dest_tag !== 12'h000) begin
      n_fail++; $display("FAIL single_idle: got %h expected 000", complete_dest_tag);
    end
  endtask

  task automatic test_burst();
    logic [5:0] e0  [9] = '{6'd1, 6'd3, 6'd5, 6'd7, 6'd9, 6'd11, 6'd13, 6'd15, 6'd0};
    logic [5:0] e1  [9] = '{6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd16, 6'd0};
    logic [3:0] eqc [9] = '{4'd2, 4'd4, 4'd6, 4'd4, 4'd6, 4'd4, 4'd2, 4'd0, 4'd0};
    logic       erdy[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int  g = 0;
    logic rdy_before;
    for (int c = 0; c < 9; c++) begin
      if (g < 4) begin
        fu_done_valid = 4'b1111;
        for (int l = 0; l < 4; l++) fu_done_tag[l] = 6'(g * 4 + l + 1);
      end else begin
        clear_inputs();
      end
      rdy_before = fu_ready;
      cyc();
      if (rdy_before && g < 4) g++;
      n_checks++;
      if (complete_dest_tag[0] !== e0[c] || complete_dest_tag[1] !== e1[c]) begin
        n_fail++; $display("FAIL burst_out[%0d]: got %0d,%0d expected %0d,%0d", c,
                           complete_dest_tag[0], complete_dest_tag[1], e0[c], e1[c]);
      end
      n_checks++;
      if (queue_count !== eqc[c]) begin
        n_fail++; $display("FAIL burst_count[%0d]: got %0d expected %0d", c, queue_count, eqc[c]);
      end
      n_checks++;
      if (fu_ready !== erdy[c]) begin
        n_fail++; $display("FAIL burst_ready[%0d]: got %b expected %b", c, fu_ready, erdy[c]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_zero_tag();
    fu_done_valid  = 4'b0011;
    fu_done_tag[0] = 6'd0;
    fu_done_tag[1] = 6'd9;
    cyc();
    clear_inputs();
    n_checks++;
    if (complete_dest_tag[0] !== 6'd9 || complete_dest_tag[1] !== 6'd0) begin
      n_fail++; $display("FAIL zero_tag_out: got %0d,%0d expected 9,0",
                         complete_dest_tag[0], complete_dest_tag[1]);
    end
    n_checks++;
    if (queue_count !== 4'd0) begin
      n_fail++; $display("FAIL zero_tag_count: got %0d expected 0", queue_count);
    end
    cyc();
    n_checks++;
    if (complete_dest_tag !== 12'h000) begin
      n_fail++; $display("FAIL zero_tag_idle: got %h expected 000", complete_dest_tag);
    end
  endtask

  task automatic test_reset_mid();
    for (int g = 0; g < 3; g++) begin
      fu_done_valid = 4'b1111;
      for (int l = 0; l < 4; l++) fu_done_tag[l] = 6'(21 + g * 4 + l);
      cyc();
    end
    n_checks++;
    if (queue_count !== 4'd6) begin
      n_fail++; $display("FAIL rst_mid_fill: got %0d expected 6", queue_count);
    end
    reset = 1'b1;
    for (int l = 0; l < 4; l++) fu_done_tag[l] = 6'(33 + l);
    cyc();
    reset = 1'b0;
    clear_inputs();
    n_checks++;
    if (complete_dest_tag !== 12'h000 || queue_count !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid_state: got cdb %h count %0d expected 000 count 0",
                         complete_dest_tag, queue_count);
    end
    n_checks++;
    if (fu_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", fu_ready);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      n_checks++;
      if (complete_dest_tag !== 12'h000 || queue_count !== 4'd0) begin
        n_fail++; $display("FAIL rst_mid_flushed[%0d]: got cdb %h count %0d expected 000 count 0",
                           c, complete_dest_tag, queue_count);
      end
    end
  endtask

  task automatic test_wrap();
    int send_next = 1;
    int exp_next  = 1;
    int mcount    = 0;
    int acc, avail, k, cycles;
    logic m_ready;
    logic [5:0] expv;
    cycles = 0;
    while ((send_next <= 60 || mcount > 0) && cycles < 100) begin
      m_ready = (8 - mcount) >= 4;
      n_checks++;
      if (fu_ready !== m_ready) begin
        n_fail++; $display("FAIL wrap_ready[%0d]: got %b expected %b", cycles, fu_ready, m_ready);
      end
      if (send_next <= 60) begin
        fu_done_valid  = 4'b1111;
        fu_done_tag[0] = 6'(send_next);
        fu_done_tag[1] = 6'(send_next + 1);
        fu_done_tag[2] = 6'd0;
        fu_done_tag[3] = 6'(send_next + 2);
        acc = m_ready ? 3 : 0;
      end else begin
        clear_inputs();
        acc = 0;
      end
      cyc();
      cycles++;
      send_next += acc;
      avail = mcount + acc;
      k = (avail < 2) ? avail : 2;
      for (int j = 0; j < 2; j++) begin
        expv = (j < k) ? 6'(exp_next + j) : 6'd0;
        n_checks++;
        if (complete_dest_tag[j] !== expv) begin
          n_fail++; $display("FAIL wrap_out[%0d] lane %0d: got %0d expected %0d",
                             cycles, j, complete_dest_tag[j], expv);
        end
      end
      exp_next += k;
      mcount = avail - k;
      n_checks++;
      if (queue_count !== 4'(mcount)) begin
        n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", cycles, queue_count, mcount);
      end
    end
    clear_inputs();
    n_checks++;
    if (exp_next != 61) begin
      n_fail++; $display("FAIL wrap_budget: reached tag %0d expected 61 within 100 cycles", exp_next);
    end
    cyc();
    n_checks++;
    if (complete_dest_tag !== 12'h000 || queue_count !== 4'd0) begin
      n_fail++; $display("FAIL wrap_idle: got cdb %h count %0d expected 000 count 0",
                         complete_dest_tag, queue_count);
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_burst();
    test_zero_tag();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_broadcast_queue.md
Name: cdb_broadcast_queue

Overview:
Completion-side producer for the rename/ROB cluster. It collects finished destination physical tags from up to N_FU functional-unit result lanes. It buffers them in order in a circular queue and broadcasts up to N_WAY tags per cycle as complete_dest_tag. That bus feeds the ROB complete logic, the map table ready bits and the reservation-station wakeup. Tag value 0 means "no completion" everywhere on the bus.

Parameters:
N_WAY, 2, superscalar width; number of CDB broadcast lanes.
N_FU, 4, number of functional-unit result lanes; must be >= N_WAY.
CDB_BITS, 6, physical tag width.
DEPTH, 8, queue entries; power of two; must be >= N_FU.

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
fu_done_valid  input  N_FU  lane i has a completed result this cycle.
fu_done_tag  input  N_FU x CDB_BITS  destination physical tag of lane i.
fu_ready  output  1  queue can accept all N_FU lanes this cycle. FUs hold their results while it is low.
complete_dest_tag  output  N_WAY x CDB_BITS  registered CDB broadcast. Zero means an idle lane.
queue_count  output  clog2(DEPTH+1)  occupied entries, registered (debug/perf).

Behaviour:
- Storage: DEPTH x CDB_BITS array, head and tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and a count register.
- fu_ready = (DEPTH - count) >= N_FU. It is combinational from the count register only, with no path from the fu_* inputs.
- Lane i is accepted iff fu_ready && fu_done_valid[i] && fu_done_tag[i] != 0.
  - A valid lane carrying tag 0 is silently dropped.
  - Lanes are not accepted while fu_ready=0; the FU must hold its result.
- Ordering key for one cycle:
  - Queue entries come first, oldest first from head.
  - Accepted lanes follow, in ascending lane index.
- Each rising edge:
  - complete_dest_tag lanes 0..k-1 load the first k items of the ordering, where k = min(N_WAY, count + accepted).
  - Lanes k..N_WAY-1 load 0. Output lanes are always compacted toward lane 0.
  - Items beyond the first N_WAY are written into the queue at the tail in the same order.
  - head advances by the number drained from the queue.
  - count_next = count + accepted - k. No overflow is possible given the fu_ready rule and DEPTH >= N_FU.
- Latency: a tag accepted in cycle t appears on complete_dest_tag no earlier than cycle t+1.
  - It appears exactly at t+1 if the queue is empty and the tag is within the first N_WAY accepted lanes.
  - Otherwise it waits its turn in FIFO order. There is no starvation.
- Each tag is broadcast exactly once, for exactly one cycle.
- Empty queue with no inputs: outputs all zero in the next cycle.
- Full condition: when count > DEPTH - N_FU, fu_ready is low. The queue still drains N_WAY per cycle and fu_ready re-asserts once free >= N_FU.
- Wrap-around: head and tail wrap with no bubbles or reordering. count distinguishes full from empty.
- Duplicate or invalid tags are not checked; upstream guarantees uniqueness.
- Reset (synchronous, takes priority over everything, valid mid-operation):
  - head = tail = count = 0.
  - complete_dest_tag = 0, queue_count = 0.
  - Queued tags are discarded and never broadcast.
  - Inputs presented in the reset cycle are not accepted.
  - fu_ready reads 1 from the first post-reset cycle.

Test Plan:
Use defaults N_WAY=2, N_FU=4, DEPTH=8, CDB_BITS=6.
1. Reset for 2 cycles -> complete_dest_tag = {0,0}, queue_count = 0, fu_ready = 1.
2. Cycle t: lane 2 valid, tag 5, other lanes idle -> cycle t+1: lane0 = 5, lane1 = 0, queue_count = 0. Cycle t+2: all zero.
3. Four consecutive cycles, all four lanes valid with tags 1..16 in order -> CDB emits 1,2 / 3,4 / 5,6 ... strictly in order.
   - queue_count = 2, 4, 6 after cycles 1-3.
   - fu_ready = 0 in cycle 4, so tags 13..16 are held by the bench until fu_ready returns to 1.
   - All 16 tags appear exactly once.
4. lane0 valid with tag 0, lane1 valid with tag 9 -> next cycle lane0 = 9, lane1 = 0. The zero tag is never broadcast.
5. Reach queue_count = 6, then assert reset for one cycle with all lanes valid -> next cycle outputs 0, queue_count = 0, fu_ready = 1. None of the 6 queued tags nor the reset-cycle inputs ever appear.
6. Sustain 3 tags/cycle input for 20 cycles with arrival-order tags -> head/tail wrap at least twice. The output sequence equals the input sequence, with no loss or duplication and no ready stall longer than needed.
